wash_timer_ctrl: RTL and testbench

Program sequencer and countdown timer for the washing machine. It steps through three fixed phases (WASH, RINSE, SPIN) and counts each phase's remaining time down in tenths of a second. It drives the minute/second/tenth and twinkle inputs of the 4-digit display driver, plus the motor and drain enables. It sits between the front-panel buttons and the display/actuator blocks.

---
 rtl/wash_timer_ctrl.sv | 145 ++++++++++++++
 tb/tb_wash_timer_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wash_timer_ctrl.sv
// wash_timer_ctrl: WASH/RINSE/SPIN program sequencer with a tenth-second countdown and run/pause/stop control.
module wash_timer_ctrl #(
  parameter int         TENTH_DIV = 240000,
  parameter logic [7:0] WASH_MIN  = 8'd5,
  parameter logic [7:0] RINSE_MIN = 8'd3,
  parameter logic [7:0] SPIN_MIN  = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_stop,
  output logic [7:0] o_minute,
  output logic [7:0] o_second,
  output logic [3:0] o_second_p,
  output logic       o_twinkle,
  output logic [1:0] o_phase,
  output logic       o_motor,
  output logic       o_drain,
  output logic       o_busy,
  output logic       o_done
);
  localparam int PW = $clog2(TENTH_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TENTH_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] min_q, min_d, sec_q, sec_d;
  logic [3:0] ten_q, ten_d;
  logic [1:0] phase_q, phase_d;
  logic twinkle_q, twinkle_d, motor_q, motor_d, drain_q, drain_d, busy_q, busy_d, done_q, done_d;
  logic tick;

  assign tick = pre_q == PMAX;

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    min_d     = min_q;
    sec_d     = sec_q;
    ten_d     = ten_q;
    phase_d   = phase_q;
    twinkle_d = twinkle_q;
    motor_d   = motor_q;
    drain_d   = drain_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (i_stop) begin
      state_d   = IDLE;
      pre_d     = '0;
      min_d     = WASH_MIN;
      sec_d     = 8'd0;
      ten_d     = 4'd0;
      phase_d   = 2'd0;
      twinkle_d = 1'b0;
      motor_d   = 1'b0;
      drain_d   = 1'b0;
      busy_d    = 1'b0;
    end else if (i_start && (state_q == IDLE || state_q == DONE)) begin
      state_d   = RUN;
      pre_d     = '0;
      min_d     = WASH_MIN;
      sec_d     = 8'd0;
      ten_d     = 4'd0;
      phase_d   = 2'd0;
      twinkle_d = 1'b0;
      motor_d   = 1'b1;
      drain_d   = 1'b0;
      busy_d    = 1'b1;
    end else if (state_q == RUN && i_pause) begin
      state_d   = PAUSE;
      twinkle_d = 1'b1;
      motor_d   = 1'b0;
      drain_d   = 1'b0;
    end else if (state_q == RUN || (state_q == PAUSE && i_pause)) begin
      // the resume edge already counts as a running cycle, so pausing adds exactly the paused cycles
      state_d   = RUN;
      twinkle_d = 1'b0;
      busy_d    = 1'b1;
      pre_d     = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (ten_q != 4'd0) begin
          ten_d = ten_q - 4'd1;
        end else if (sec_q != 8'd0) begin
          ten_d = 4'd9;
          sec_d = sec_q - 8'd1;
        end else if (min_q != 8'd0) begin
          ten_d = 4'd9;
          sec_d = 8'd59;
          min_d = min_q - 8'd1;
        end else if (phase_q == 2'd2) begin
          state_d   = DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          twinkle_d = 1'b1;
        end else begin
          phase_d = phase_q + 2'd1;
          min_d   = phase_q == 2'd0 ? RINSE_MIN : SPIN_MIN;
        end
      end
      motor_d = state_d == RUN;
      drain_d = state_d == RUN && phase_d == 2'd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      min_q     <= WASH_MIN;
      sec_q     <= 8'd0;
      ten_q     <= 4'd0;
      phase_q   <= 2'd0;
      twinkle_q <= 1'b0;
      motor_q   <= 1'b0;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      ten_q     <= ten_d;
      phase_q   <= phase_d;
      twinkle_q <= twinkle_d;
      motor_q   <= motor_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_minute   = min_q;
  assign o_second   = sec_q;
  assign o_second_p = ten_q;
  assign o_twinkle  = twinkle_q;
  assign o_phase    = phase_q;
  assign o_motor    = motor_q;
  assign o_drain    = drain_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
endmodule

// File: tb/tb_wash_timer_ctrl.sv
// tb_wash_timer_ctrl: directed checks of countdown, phases, pause/resume, priority, async reset and restart.
module tb_wash_timer_ctrl;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
  logic [7:0] o_minute, o_second;
  logic [3:0] o_second_p;
  logic [1:0] o_phase;
  logic o_twinkle, o_motor, o_drain, o_busy, o_done;
  int checks = 0, errors = 0;

  wash_timer_ctrl #(.TENTH_DIV(4), .WASH_MIN(8'd1), .RINSE_MIN(8'd1), .SPIN_MIN(8'd1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .o_minute(o_minute), .o_second(o_second), .o_second_p(o_second_p), .o_twinkle(o_twinkle),
    .o_phase(o_phase), .o_motor(o_motor), .o_drain(o_drain), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string tag, input int m, input int s, input int t);
    chk({tag, "_min"}, 32'(o_minute), 32'(m));
    chk({tag, "_sec"}, 32'(o_second), 32'(s));
    chk({tag, "_tenth"}, 32'(o_second_p), 32'(t));
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    chk_time("reset", 1, 0, 0);
    chk("reset_phase", 32'(o_phase), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_motor", 32'(o_motor), 0);
    chk("reset_twinkle", 32'(o_twinkle), 0);
    chk("reset_done", 32'(o_done), 0);

    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    chk_time("start", 1, 0, 0);
    chk("start_busy", 32'(o_busy), 1);
    chk("start_motor", 32'(o_motor), 1);
    chk("start_drain", 32'(o_drain), 0);
    step(4);
    chk_time("borrow4", 0, 59, 9);
    step(36);
    chk_time("borrow40", 0, 59, 0);
    step(4);
    chk_time("borrow44", 0, 58, 9);

    #3 rst = 1'b1;
    #1;
    chk_time("async_rst", 1, 0, 0);
    chk("async_rst_motor", 32'(o_motor), 0);
    chk("async_rst_busy", 32'(o_busy), 0);
    #2 rst = 1'b0;
    step(1);

    i_start = 1'b1;
    i_pause = 1'b1;
    step(1);
    i_start = 1'b0;
    i_pause = 1'b0;
    chk("prio_start_busy", 32'(o_busy), 1);
    chk("prio_start_motor", 32'(o_motor), 1);
    chk("prio_start_twinkle", 32'(o_twinkle), 0);
    step(5);
    i_pause = 1'b1;
    step(1);
    i_pause = 1'b0;
    chk_time("pause", 0, 59, 9);
    chk("pause_motor", 32'(o_motor), 0);
    chk("pause_twinkle", 32'(o_twinkle), 1);
    chk("pause_busy", 32'(o_busy), 1);
    step(100);
    chk_time("pause100", 0, 59, 9);
    chk("pause100_motor", 32'(o_motor), 0);
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    chk("start_in_pause_motor", 32'(o_motor), 0);
    chk("start_in_pause_twinkle", 32'(o_twinkle), 1);
    i_pause = 1'b1;
    step(1);
    i_pause = 1'b0;
    chk("resume_motor", 32'(o_motor), 1);
    chk("resume_twinkle", 32'(o_twinkle), 0);
    chk_time("resume", 0, 59, 9);
    step(1);
    chk_time("resume1", 0, 59, 9);
    step(1);
    chk_time("resume2", 0, 59, 8);

    i_stop = 1'b1;
    i_pause = 1'b1;
    step(1);
    i_stop = 1'b0;
    i_pause = 1'b0;
    chk_time("stop", 1, 0, 0);
    chk("stop_busy", 32'(o_busy), 0);
    chk("stop_motor", 32'(o_motor), 0);
    chk("stop_twinkle", 32'(o_twinkle), 0);

    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    step(2403);
    chk("wash_end_phase", 32'(o_phase), 0);
    chk_time("wash_end", 0, 0, 0);
    step(1);
    chk("rinse_phase", 32'(o_phase), 1);
    chk_time("rinse_load", 1, 0, 0);
    chk("rinse_drain", 32'(o_drain), 0);
    step(2403);
    chk("rinse_end_drain", 32'(o_drain), 0);
    step(1);
    chk("spin_phase", 32'(o_phase), 2);
    chk("spin_drain", 32'(o_drain), 1);
    chk("spin_motor", 32'(o_motor), 1);
    step(2403);
    chk("pre_done", 32'(o_done), 0);
    chk("pre_done_busy", 32'(o_busy), 1);
    step(1);
    chk("done_pulse", 32'(o_done), 1);
    chk("done_busy", 32'(o_busy), 0);
    chk("done_motor", 32'(o_motor), 0);
    chk("done_drain", 32'(o_drain), 0);
    chk("done_twinkle", 32'(o_twinkle), 1);
    chk("done_phase", 32'(o_phase), 2);
    chk_time("done", 0, 0, 0);
    step(1);
    chk("done_single", 32'(o_done), 0);
    chk("done_twinkle_hold", 32'(o_twinkle), 1);
    i_pause = 1'b1;
    step(1);
    i_pause = 1'b0;
    chk("done_pause_busy", 32'(o_busy), 0);
    chk("done_pause_twinkle", 32'(o_twinkle), 1);

    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    chk("restart_phase", 32'(o_phase), 0);
    chk_time("restart", 1, 0, 0);
    chk("restart_twinkle", 32'(o_twinkle), 0);
    chk("restart_busy", 32'(o_busy), 1);
    chk("restart_motor", 32'(o_motor), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
